fringe_counter: RTL and testbench
=================================

// Module: fringe_counter
// PURPOSE
//  Consumes the two-channel (A/B quadrature) sample stream together with EF_lower_threshold and
//  EF_upper_threshold from extremum_finder, in parallel with it on the same stream.
//  Per channel: Schmitt trigger (hysteresis = the thresholds); then a quadrature decoder.
//  Keeps a signed fringe position count; emits that count on an AXI-Stream master, one word per accepted sample.
// PARAMETERS
//  AXIS_TDATA_WIDTH  32  input word: signal_a = [W/2-1:0], signal_b = [W-1:W/2], both signed
//  COUNT_WIDTH       32  position counter width; must be <= AXIS_TDATA_WIDTH
// PORTS
//  aclk                 in   1      clock
//  aresetn              in   1      asynchronous active-low reset
//  EF_lower_threshold   in   W/2    signed low threshold
//  EF_upper_threshold   in   W/2    signed high threshold
//  FC_clear             in   1      synchronous pulse: zero the position and re-prime
//  FC_error_count       out  16     illegal-transition count (see CONFIGURATION)
//  S_AXIS_tvalid        in   1      sample valid
//  S_AXIS_tdata         in   W      {signal_b, signal_a}
//  S_AXIS_tready        out  1      = M_AXIS_tready | ~M_AXIS_tvalid
//  M_AXIS_tvalid        out  1      position word valid
//  M_AXIS_tdata         out  W      sign-extended position
//  M_AXIS_tready        in   1      downstream ready
// BEHAVIOUR
//  Reset (async): position=0, bits{a,b}=00, state=PRIME, M_AXIS_tvalid=0, M_AXIS_tdata=0, FC_error_count=0.
//  Accept: sample taken when S_AXIS_tvalid & S_AXIS_tready.
//  Output timing: M_AXIS_tvalid=1 and tdata=new position on the next clock edge (latency 1).
//  Output hold: tvalid/tdata hold until M_AXIS_tready. Full throughput when M_AXIS_tready=1.
//  Per-channel Schmitt trigger, signed compares: x > upper -> bit=1; x < lower -> bit=0; else hold.
//    Thresholds invalid when $signed(lower) >= $signed(upper), e.g. extremum_finder reset values 0x7FFF/0x8000.
//    While invalid: bits held, no count change. Samples are still accepted and output words still produced.
//  State PRIME: first accepted sample loads the new bits with no count change -> TRACK.
//    Output word is still produced.
//  State TRACK: compare old {a,b} with new {a,b}, Gray sequence 00->01->11->10->00:
//    forward step: position+1
//    backward step: position-1
//    no change: hold
//    both bits changed: illegal; position held, error counter +1
//  Wrap: position wraps two's complement, 0x7FFFFFFF +1 -> 0x80000000. Error counter saturates at 0xFFFF.
//  FC_clear: position=0, state=PRIME, error count=0. The output register is not flushed.
//    FC_clear together with an accept: clear wins. The sample primes the bits.
//    That output word carries 0.
//  Thresholds are sampled on the accept cycle. A threshold change between samples takes effect on the next accept.
//  Stall: no state change while the input is not accepted.
//  aresetn asserted mid-stream: immediate return to reset values; any pending output word is dropped.
// CONFIGURATION
//  FRINGE_COUNTER_ERROR_COUNT_EN defined: 16-bit saturating illegal-transition counter drives FC_error_count.
//  Not defined: counter logic removed, FC_error_count tied to 0. Illegal transitions still hold position.
// TESTING
//  1 Thresholds lo=-1000, hi=1000.
//    Feed (a,b) = (-2000,-2000), (2000,-2000), (2000,2000), (-2000,2000), (-2000,-2000).
//    -> outputs 0,1,2,3,4.
//  2 Same thresholds, reverse sequence from 00 (00,10,11,01,00) -> 0,-1,-2,-3,-4.
//    Samples at +/-500 in between -> no change (hysteresis hold).
//  3 Jump 00->11 -> position held.
//    Macro defined: FC_error_count=1. Macro undefined: FC_error_count=0.
//  4 lo=0x7FFF, hi=0x8000, any samples -> position stays 0, one output per input.
//  5 M_AXIS_tready=0 for 5 cycles with input valid -> S_AXIS_tready=0 and tdata held; no sample lost.
//  6 Preload position 0x7FFFFFFF via forward steps (or force), one forward step -> 0x80000000.
//    FC_clear with accept -> output 0.

Source files
------------

// File: rtl/fringe_counter_if.sv
// Bus bundle for fringe_counter: sample stream in, thresholds/clear in, position stream out.
interface fringe_counter_if #(
   parameter int W = 32
);
   logic [W/2-1:0] EF_lower_threshold;
   logic [W/2-1:0] EF_upper_threshold;
   logic           FC_clear;
   logic [15:0]    FC_error_count;
   logic           S_AXIS_tvalid;
   logic [W-1:0]   S_AXIS_tdata;
   logic           S_AXIS_tready;
   logic           M_AXIS_tvalid;
   logic [W-1:0]   M_AXIS_tdata;
   logic           M_AXIS_tready;

   modport master (
      output EF_lower_threshold, EF_upper_threshold, FC_clear,
      output S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
      input  FC_error_count, S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata
   );

   modport slave (
      input  EF_lower_threshold, EF_upper_threshold, FC_clear,
      input  S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
      output FC_error_count, S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata
   );
endinterface

// File: rtl/fringe_counter.sv
// Quadrature fringe counter: per-channel Schmitt trigger, Gray decoder, signed position stream.
// Define FRINGE_COUNTER_ERROR_COUNT_EN to enable the saturating illegal-transition counter.
module fringe_counter #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int COUNT_WIDTH      = 32
) (
   input  logic             aclk,
   input  logic             aresetn,
   fringe_counter_if.slave  bus
);
   localparam int W  = AXIS_TDATA_WIDTH;
   localparam int HW = W / 2;

   typedef enum logic {PRIME, TRACK} state_t;

   state_t                         state_reg, state_next;
   logic [1:0]                     bits_reg, bits_next;      // {b, a}
   logic signed [COUNT_WIDTH-1:0]  position_reg, position_next;
   logic                           m_valid_reg;
   logic [W-1:0]                   m_data_reg;
   logic [W-1:0]                   position_ext;

   logic                           s_ready;
   logic                           accept;
   logic                           thr_valid;
   logic [1:0]                     sample_bits;
   logic [1:0]                     fwd_bits, bwd_bits;
   logic signed [HW-1:0]           lower, upper;
   logic signed [HW-1:0]           chan [2];

   assign lower   = bus.EF_lower_threshold;
   assign upper   = bus.EF_upper_threshold;
   assign chan[0] = bus.S_AXIS_tdata[HW-1:0];
   assign chan[1] = bus.S_AXIS_tdata[W-1:HW];

   assign s_ready           = bus.M_AXIS_tready | ~m_valid_reg;
   assign accept            = bus.S_AXIS_tvalid & s_ready;
   assign thr_valid         = lower < upper;
   assign bus.S_AXIS_tready = s_ready;
   assign bus.M_AXIS_tvalid = m_valid_reg;
   assign bus.M_AXIS_tdata  = m_data_reg;

   // Invalid thresholds collapse both triggers to "hold".
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_schmitt
         assign sample_bits[gi] = !thr_valid        ? bits_reg[gi] :
                                  (chan[gi] > upper) ? 1'b1 :
                                  (chan[gi] < lower) ? 1'b0 : bits_reg[gi];
      end
   endgenerate

   // Gray order in {b,a}: 00 -> 01 -> 11 -> 10 -> 00 is forward (channel a leads).
   assign fwd_bits = {bits_reg[0], ~bits_reg[1]};
   assign bwd_bits = {~bits_reg[0], bits_reg[1]};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_reg <= PRIME;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (bus.FC_clear)  state_next = accept ? TRACK : PRIME;
      else if (accept)   state_next = TRACK;
   end

   always_comb begin
      bits_next     = bits_reg;
      position_next = position_reg;
      if (bus.FC_clear) begin
         position_next = '0;
         if (accept) bits_next = sample_bits;
      end else if (accept) begin
         bits_next = sample_bits;
         if (state_reg == TRACK) begin
            if (sample_bits == fwd_bits)      position_next = position_reg + 1'b1;
            else if (sample_bits == bwd_bits) position_next = position_reg - 1'b1;
         end
      end
   end

   generate
      if (W > COUNT_WIDTH) begin : g_sext
         assign position_ext = {{(W-COUNT_WIDTH){position_next[COUNT_WIDTH-1]}}, position_next};
      end else begin : g_noext
         assign position_ext = position_next;
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bits_reg     <= 2'b00;
         position_reg <= '0;
         m_valid_reg  <= 1'b0;
         m_data_reg   <= '0;
      end else begin
         bits_reg     <= bits_next;
         position_reg <= position_next;
         if (accept) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= position_ext;
         end else if (bus.M_AXIS_tready) begin
            m_valid_reg <= 1'b0;
         end
      end
   end

`ifdef FRINGE_COUNTER_ERROR_COUNT_EN
   logic        illegal;
   logic [15:0] err_reg;

   assign illegal = accept & ~bus.FC_clear & (state_reg == TRACK) &
                    ((sample_bits ^ bits_reg) == 2'b11);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                         err_reg <= '0;
      else if (bus.FC_clear)                err_reg <= '0;
      else if (illegal && err_reg != 16'hFFFF) err_reg <= err_reg + 16'd1;
   end

   assign bus.FC_error_count = err_reg;
`else
   assign bus.FC_error_count = 16'd0;
`endif
endmodule

// File: tb/tb_fringe_counter.sv
// Directed scoreboard bench for fringe_counter: expected words queued on accept, checked on output handshake.
module tb_fringe_counter;
   localparam int H = 2000;
   localparam int L = -2000;

   logic aclk = 1'b0;
   logic aresetn;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic [31:0] exp_q [$];
   logic [15:0] exp_err;

   fringe_counter_if #(.W(32)) bus ();

   fringe_counter #(.AXIS_TDATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   always @(negedge aclk) begin
      if (aresetn && bus.M_AXIS_tvalid && bus.M_AXIS_tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", bus.M_AXIS_tdata, 32'hDEAD_BEEF);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("out_word", bus.M_AXIS_tdata, e);
            $display("word out: %0d (expected %0d)", $signed(bus.M_AXIS_tdata), $signed(e));
         end
      end
   end

   task automatic send(input int a, input int b, input int expv, input logic clr);
      logic done;
      logic [31:0] av, bv;
      av = a;
      bv = b;
      done = 1'b0;
      bus.S_AXIS_tvalid = 1'b1;
      bus.S_AXIS_tdata  = {bv[15:0], av[15:0]};
      bus.FC_clear      = clr;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge aclk);
         if (bus.S_AXIS_tready) begin
            exp_q.push_back(32'(expv));
            done = 1'b1;
         end
      end
      if (!done) check("accept_timeout", 32'd0, 32'd1);
      @(posedge aclk);
      #1;
      bus.S_AXIS_tvalid = 1'b0;
      bus.FC_clear      = 1'b0;
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge aclk);
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn                = 1'b0;
      bus.EF_lower_threshold = 16'(-1000);
      bus.EF_upper_threshold = 16'd1000;
      bus.FC_clear           = 1'b0;
      bus.S_AXIS_tvalid      = 1'b0;
      bus.S_AXIS_tdata       = '0;
      bus.M_AXIS_tready      = 1'b1;
`ifdef FRINGE_COUNTER_ERROR_COUNT_EN
      exp_err = 16'd1;
`else
      exp_err = 16'd0;
`endif
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_m_tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
      check("rst_m_tdata", bus.M_AXIS_tdata, 32'd0);
      check("rst_s_tready", 32'(bus.S_AXIS_tready), 32'd1);
      check("rst_err", 32'(bus.FC_error_count), 32'd0);
      @(posedge aclk);
      #1;

      // forward sequence, first sample primes
      send(L, L, 0, 1'b0);
      send(H, L, 1, 1'b0);
      send(H, H, 2, 1'b0);
      send(L, H, 3, 1'b0);
      send(L, L, 4, 1'b0);

      // clear with accept, then backward with hysteresis holds
      send(L, L, 0, 1'b1);
      send(L, H, -1, 1'b0);
      send(500, 500, -1, 1'b0);
      send(H, H, -2, 1'b0);
      send(-500, 500, -2, 1'b0);
      send(H, L, -3, 1'b0);
      send(L, L, -4, 1'b0);

      // illegal jump 00 -> 11
      send(H, H, -4, 1'b0);
      drain();
      check("err_after_jump", 32'(bus.FC_error_count), 32'(exp_err));

      // invalid thresholds
      bus.EF_lower_threshold = 16'h7FFF;
      bus.EF_upper_threshold = 16'h8000;
      send(H, L, 0, 1'b1);
      send(H, H, 0, 1'b0);
      send(L, H, 0, 1'b0);
      bus.EF_lower_threshold = 16'(-1000);
      bus.EF_upper_threshold = 16'd1000;
      send(L, L, 0, 1'b1);
      drain();
      check("err_after_clear", 32'(bus.FC_error_count), 32'd0);

      // backpressure
      bus.M_AXIS_tready = 1'b0;
      send(H, L, 1, 1'b0);
      bus.S_AXIS_tvalid = 1'b1;
      bus.S_AXIS_tdata  = {16'(H), 16'(H)};
      repeat (5) begin
         @(negedge aclk);
         check("stall_s_tready", 32'(bus.S_AXIS_tready), 32'd0);
         check("stall_m_tvalid", 32'(bus.M_AXIS_tvalid), 32'd1);
         check("stall_m_tdata", bus.M_AXIS_tdata, 32'd1);
      end
      @(posedge aclk);
      #1;
      bus.M_AXIS_tready = 1'b1;
      send(H, H, 2, 1'b0);
      drain();

      // wrap at the top of the signed range
      @(negedge aclk);
      force dut.position_reg = 32'h7FFF_FFFF;
      @(posedge aclk);
      #1;
      release dut.position_reg;
      send(L, H, 32'h8000_0000, 1'b0);
      send(L, L, 0, 1'b1);
      send(H, L, 1, 1'b0);
      drain();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
